snake_body_update: RTL
======================

# snake_body_update

Owns the snake's body register array and length. Each game tick it advances the head one grid cell in the requested direction and shifts every segment back one slot. It grows the snake when an apple has been eaten and detects wall and self collisions. It sits directly upstream of the per-pixel location checker, which consumes `body` and `curr_length` unchanged.

## Interface
- `MAX_LENGTH`, default 50: number of body slots, including the head.
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle pulse: IDLE→RUN, or DEAD→IDLE (re-initialise).
- `move_tick`  input  1  single-cycle pulse: perform one move.
- `dir_req`  input  2  requested direction, type `dir_t`.
- `grow`  input  1  single-cycle pulse: apple eaten.
- `body`  output  [MAX_LENGTH-1:0][7:0]  segment coordinates.
  - Coordinate format: [7:4] = x, [3:0] = y, on a 16×16 grid.
  - `body[0]` is the head.
- `curr_length`  output  7  number of valid segments behind the head; valid slots are 1..curr_length.
- `game_over`  output  1  high while in DEAD.
- `moved`  output  1  single-cycle pulse, high the cycle after a move is committed.

## Operation
- States:
  - IDLE: body at its initial value; ticks ignored; `start` → RUN.
  - RUN: moves are processed; collision → DEAD.
  - DEAD: body frozen; `start` → IDLE, with the body re-initialised.
- Initial value (reset, and on DEAD→IDLE):
  - body[0] = 8'h77, body[1] = 8'h67, body[2] = 8'h57; all other slots 8'h00.
  - curr_length = 2; cur_dir = RIGHT; grow_pending = 0; state = IDLE.
- Direction update:
  - On `move_tick`, cur_dir ← dir_req unless dir_req is the exact opposite of cur_dir. A reversal is ignored and cur_dir is kept.
  - The direction used for the move is this updated cur_dir.
- Next head: RIGHT = x+1, LEFT = x−1, UP = y−1, DOWN = y+1. 4-bit fields, no wrap.
- Wall collision:
  - Any of: x==15 & RIGHT, x==0 & LEFT, y==0 & UP, y==15 & DOWN.
  - Result: → DEAD, body unchanged.
- Self collision:
  - Next head equals body[i] for 1 ≤ i < curr_length.
  - If growing this move, i == curr_length is also included, because the tail does not vacate its slot.
  - Result: → DEAD, body unchanged.
- Growth:
  - `grow` sets grow_pending, which is consumed by the next committed move.
  - On a grow move, curr_length increments, saturating at MAX_LENGTH−1; the shifted-in old tail becomes valid.
  - At saturation, grow_pending is cleared with no length change.
- Commit (no collision):
  - body[0] ← next head; body[i] ← body[i−1] for i = 1..MAX_LENGTH−1.
  - `moved` pulses.

## Timing
- All outputs are registered.
- Reset values: body and curr_length at their initial values; `game_over` = 0; `moved` = 0.
- Move latency: `move_tick` in cycle N → new `body`/`curr_length` visible and `moved` = 1 in cycle N+1.
- Collision: `game_over` rises in cycle N+1; `moved` stays 0.
- `grow` and `move_tick` in the same cycle: the growth applies to that move.
- `grow` in IDLE or DEAD: ignored. grow_pending is cleared on entry to IDLE.
- `move_tick` and `start` in the same cycle:
  - In IDLE: `start` wins; no move that cycle.
  - In DEAD: the tick is ignored.
- `rst` asserted mid-move: all state returns to the initial value immediately. No partial shift is ever visible.

## Structure
- `snake_pkg` holds:
  - `dir_t` (RIGHT = 0, LEFT = 1, UP = 2, DOWN = 3) and `state_t` (IDLE, RUN, DEAD).
  - Initial head/body constants; GRID_MAX = 15.
- Sub-module `snake_next_head`: combinational. Takes head, dir → next_head, wall_hit.
- Self-collision compare loop and shift register live in the top level.

## Test plan
- Start, then 3 ticks with dir_req = RIGHT → body[0..2] = 8'hA7, 8'h97, 8'h87; `moved` pulses 3×; curr_length = 2.
- From reset: start, dir_req = LEFT, tick → reversal rejected; body[0] = 8'h87.
- grow + tick in the same cycle → curr_length = 3, body[3] = 8'h57; later a grow pulse alone followed by a tick → curr_length = 4.
- Head at 8'hF7 moving RIGHT, tick → `game_over` = 1 next cycle, body unchanged; start → IDLE with the initial body.
- Length 4 snake steered into its own segment → DEAD.
  - Also: a move into the exact tail cell without growth → legal commit.
- Saturation and reset:
  - MAX_LENGTH = 4: repeated grows → curr_length saturates at 3.
  - `rst` pulsed mid-run → initial values, `game_over` = 0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body datapath.
package snake_pkg;

   typedef enum logic [1:0] {
      RIGHT = 2'd0,
      LEFT  = 2'd1,
      UP    = 2'd2,
      DOWN  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } state_t;

   localparam logic [7:0] INIT_HEAD = 8'h77;
   localparam logic [7:0] INIT_B1   = 8'h67;
   localparam logic [7:0] INIT_B2   = 8'h57;
   localparam logic [3:0] GRID_MAX  = 4'd15;

   // Opposite pairs differ only in bit 0 (RIGHT/LEFT, UP/DOWN).
   function automatic logic is_opposite(dir_t a, dir_t b);
      return (a ^ b) == 2'b01;
   endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head coordinate and wall detection for one grid step.
module snake_next_head
   import snake_pkg::*;
(
   input  logic [7:0] head_i,
   input  dir_t       dir_i,
   output logic [7:0] next_head_o,
   output logic       wall_hit_o
);

   logic [3:0] x;
   logic [3:0] y;
   logic [3:0] nx;
   logic [3:0] ny;

   assign x = head_i[7:4];
   assign y = head_i[3:0];

   always_comb begin
      nx         = x;
      ny         = y;
      wall_hit_o = 1'b0;
      unique case (dir_i)
         RIGHT: begin
            nx         = x + 4'd1;
            wall_hit_o = (x == GRID_MAX);
         end
         LEFT: begin
            nx         = x - 4'd1;
            wall_hit_o = (x == 4'd0);
         end
         UP: begin
            ny         = y - 4'd1;
            wall_hit_o = (y == 4'd0);
         end
         DOWN: begin
            ny         = y + 4'd1;
            wall_hit_o = (y == GRID_MAX);
         end
         default: ;
      endcase
   end

   assign next_head_o = {nx, ny};

endmodule

// File: rtl/snake_body_update.sv
// Snake body shift register, length, growth and collision state machine.
module snake_body_update
   import snake_pkg::*;
#(
   parameter int MAX_LENGTH = 50
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        move_tick,
   input  dir_t                        dir_req,
   input  logic                        grow,
   output logic [MAX_LENGTH-1:0][7:0]  body,
   output logic [6:0]                  curr_length,
   output logic                        game_over,
   output logic                        moved
);

   localparam logic [6:0] LEN_MAX = 7'(MAX_LENGTH - 1);

   typedef logic [MAX_LENGTH-1:0][7:0] body_t;

   function automatic body_t init_body();
      body_t b;
      b    = '0;
      b[0] = INIT_HEAD;
      b[1] = INIT_B1;
      b[2] = INIT_B2;
      return b;
   endfunction

   state_t     state_q;
   dir_t       dir_q;
   logic       grow_q;
   body_t      body_q;
   body_t      body_d;
   logic [6:0] len_q;
   logic [6:0] len_d;
   logic       moved_q;
   logic       over_q;

   dir_t       dir_new;
   logic [7:0] next_head;
   logic       wall_hit;
   logic       self_hit;
   logic       grow_eff;
   logic       growing;

   assign dir_new  = is_opposite(dir_req, dir_q) ? dir_q : dir_req;
   assign grow_eff = grow_q | grow;
   assign growing  = grow_eff && (len_q < LEN_MAX);

   snake_next_head u_next_head (
      .head_i      (body_q[0]),
      .dir_i       (dir_new),
      .next_head_o (next_head),
      .wall_hit_o  (wall_hit)
   );

   // The tail slot only blocks the head when it stays put (growing move).
   always_comb begin
      self_hit = 1'b0;
      for (int i = 1; i < MAX_LENGTH; i++) begin
         if (body_q[i] == next_head &&
             (i < int'(len_q) || (growing && i == int'(len_q))))
            self_hit = 1'b1;
      end
   end

   assign body_d = {body_q[MAX_LENGTH-2:0], next_head};
   assign len_d  = growing ? len_q + 7'd1 : len_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dir_q   <= RIGHT;
         grow_q  <= 1'b0;
         body_q  <= init_body();
         len_q   <= 7'd2;
         moved_q <= 1'b0;
         over_q  <= 1'b0;
      end else begin
         moved_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start)
                  state_q <= RUN;
            end
            RUN: begin
               if (move_tick) begin
                  dir_q <= dir_new;
                  if (wall_hit || self_hit) begin
                     state_q <= DEAD;
                     over_q  <= 1'b1;
                  end else begin
                     body_q  <= body_d;
                     len_q   <= len_d;
                     moved_q <= 1'b1;
                     if (grow_eff)
                        grow_q <= 1'b0;
                  end
               end else if (grow) begin
                  grow_q <= 1'b1;
               end
            end
            DEAD: begin
               if (start) begin
                  state_q <= IDLE;
                  dir_q   <= RIGHT;
                  grow_q  <= 1'b0;
                  body_q  <= init_body();
                  len_q   <= 7'd2;
                  over_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign body        = body_q;
   assign curr_length = len_q;
   assign game_over   = over_q;
   assign moved       = moved_q;

endmodule
